// File: rtl/sm83_alu_flags_bank_if.sv
// Flag-unit bus interface: control decoder / ALU side (master) and the flag unit (slave).
interface sm83_alu_flags_bank_if #(
  parameter int NSEC         = 2,
  parameter int SHADOW_DEPTH = 2
);
  localparam int LVL_W = $clog2(SHADOW_DEPTH + 1);
  localparam int SEL_W = (NSEC > 1) ? $clog2(NSEC) : 1;

  logic [7:0]       din;
  logic [7:0]       dout;
  logic             flags_bus, flags_alu;
  logic             zero_we, zero_clr;
  logic             neg_we, neg_set, neg_clr;
  logic             hc_we, hc_set, hc_cpl;
  logic             daa_we;
  logic             carry_we, carry_set, carry_cpl;
  logic             sec_we;
  logic [1:0]       sec_src;
  logic [SEL_W-1:0] sec_wsel, sec_rsel;
  logic             sec_sel;
  logic             zero_in, carry_in, shift_out_in, daa_carry_in, sign_in;
  logic             push, pop, err_clr;
  logic             zero, neg, half_carry, daa_carry, carry, pri_carry;
  logic [LVL_W-1:0] shadow_level;
  logic             shadow_full, shadow_empty, shadow_err;

  modport master (
    output din, flags_bus, flags_alu, zero_we, zero_clr, neg_we, neg_set, neg_clr,
           hc_we, hc_set, hc_cpl, daa_we, carry_we, carry_set, carry_cpl,
           sec_we, sec_src, sec_wsel, sec_rsel, sec_sel,
           zero_in, carry_in, shift_out_in, daa_carry_in, sign_in, push, pop, err_clr,
    input  dout, zero, neg, half_carry, daa_carry, carry, pri_carry,
           shadow_level, shadow_full, shadow_empty, shadow_err
  );

  modport slave (
    input  din, flags_bus, flags_alu, zero_we, zero_clr, neg_we, neg_set, neg_clr,
           hc_we, hc_set, hc_cpl, daa_we, carry_we, carry_set, carry_cpl,
           sec_we, sec_src, sec_wsel, sec_rsel, sec_sel,
           zero_in, carry_in, shift_out_in, daa_carry_in, sign_in, push, pop, err_clr,
    output dout, zero, neg, half_carry, daa_carry, carry, pri_carry,
           shadow_level, shadow_full, shadow_empty, shadow_err
  );
endinterface

// File: rtl/sm83_alu_flags_bank.sv
// SM83 flag unit: Z/N/H/C, secondary carry bank, DAA half-carry and a LIFO
// flag shadow stack for context save/restore.
// Optional macro SM83_FLAGS_BYPASS_EN: flag outputs show the value being
// written this cycle (write-through) instead of the registered value.
module sm83_alu_flags_bank #(
  parameter int NSEC         = 2,
  parameter int SHADOW_DEPTH = 2
) (
  input logic                  clk,
  input logic                  nreset,
  sm83_alu_flags_bank_if.slave fb
);
  localparam int LVL_W = $clog2(SHADOW_DEPTH + 1);
  localparam int SEL_W = (NSEC > 1) ? $clog2(NSEC) : 1;
  // Storage is rounded up to a power of two so indices never run off the end;
  // entries beyond NSEC / SHADOW_DEPTH are never written and stay zero.
  localparam int SEC_N = 1 << SEL_W;
  localparam int STK_N = 1 << LVL_W;
  localparam logic [SEL_W:0]   NSEC_V  = NSEC[SEL_W:0];
  localparam logic [LVL_W-1:0] DEPTH_V = SHADOW_DEPTH[LVL_W-1:0];

  logic             z_q, n_q, h_q, c_q, daa_q, err_q;
  logic [SEC_N-1:0] sec_q, sec_nx;
  logic [3:0]       stk_q [STK_N];
  logic [LVL_W-1:0] level_q, top_idx;

  logic [3:0] wr_src, cur, wr_flags, nx_flags, vis_flags;
  logic [SEC_N-1:0] vis_sec;
  logic full, empty, fault, st_err, do_push, do_pop, do_xchg;
  logic sec_val, sec_wr, daa_nx, rsel_ok, sec_rd;
  logic unused_din;

  assign unused_din = ^fb.din[3:0];

  // Write sources are one-hot, so OR-ing the masked bus and ALU values selects one.
  assign wr_src = (fb.din[7:4] & {4{fb.flags_bus}})
                | ({fb.zero_in, fb.sign_in, fb.carry_in, fb.carry_in} & {4{fb.flags_alu}});

  assign cur     = {z_q, n_q, h_q, c_q};
  assign full    = (level_q == DEPTH_V);
  assign empty   = (level_q == '0);
  assign top_idx = level_q - LVL_W'(1);

  // Push on full or pop on empty freezes every register; push+pop on empty acts as push.
  assign fault   = (fb.push & ~fb.pop & full) | (fb.pop & ~fb.push & empty);
  assign st_err  = fault | (fb.push & fb.pop & empty);
  assign do_push = fb.push & ~fault & (~fb.pop | empty);
  assign do_pop  = fb.pop & ~fb.push & ~fault;
  assign do_xchg = fb.push & fb.pop & ~empty;

  assign sec_wr = fb.sec_we & ~fault & ({1'b0, fb.sec_wsel} < NSEC_V);
  assign daa_nx = (fb.daa_we & ~fault) ? wr_src[1] : daa_q;

  // Next flag and secondary-bank values from the write controls and the stack.
  always_comb begin
    wr_flags[3] = (fb.zero_we | fb.zero_clr) ? (~fb.zero_clr & wr_src[3]) : z_q;
    wr_flags[2] = fb.neg_clr ? 1'b0 : fb.neg_set ? 1'b1 : fb.neg_we ? wr_src[2] : n_q;
    wr_flags[1] = fb.hc_we ? wr_src[1] : h_q;
    wr_flags[0] = (fb.carry_we & ~fb.sec_we) ? wr_src[0] : c_q;

    if (fault)                nx_flags = cur;
    else if (do_pop | do_xchg) nx_flags = stk_q[top_idx];
    else                      nx_flags = wr_flags;

    case (fb.sec_src)
      2'b00:   sec_val = fb.carry_in;
      2'b01:   sec_val = fb.shift_out_in;
      2'b10:   sec_val = fb.daa_carry_in;
      default: sec_val = 1'b0;
    endcase

    sec_nx = sec_q;
    if (sec_wr) sec_nx[fb.sec_wsel] = sec_val;
  end

`ifdef SM83_FLAGS_BYPASS_EN
  assign vis_flags = nx_flags;
  assign vis_sec   = sec_nx;
`else
  assign vis_flags = cur;
  assign vis_sec   = sec_q;
`endif

  assign rsel_ok = ({1'b0, fb.sec_rsel} < NSEC_V);
  assign sec_rd  = rsel_ok & vis_sec[fb.sec_rsel];

  assign fb.zero         = vis_flags[3];
  assign fb.neg          = vis_flags[2];
  assign fb.half_carry   = (vis_flags[1] | fb.hc_set) ^ fb.hc_cpl;
  assign fb.pri_carry    = vis_flags[0];
  assign fb.carry        = ((fb.sec_sel ? sec_rd : vis_flags[0]) | fb.carry_set) ^ fb.carry_cpl;
  assign fb.daa_carry    = daa_q;
  assign fb.dout         = {fb.zero, fb.neg, fb.half_carry, fb.carry, 4'b0000};
  assign fb.shadow_level = level_q;
  assign fb.shadow_full  = full;
  assign fb.shadow_empty = empty;
  assign fb.shadow_err   = err_q;

  // Register update: flags, secondary bank, DAA, shadow stack and sticky error.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      {z_q, n_q, h_q, c_q} <= '0;
      daa_q   <= 1'b0;
      sec_q   <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STK_N; i++) stk_q[i] <= '0;
    end else begin
      {z_q, n_q, h_q, c_q} <= nx_flags;
      daa_q <= daa_nx;
      sec_q <= sec_nx;
      if (do_push) begin
        stk_q[level_q] <= cur;
        level_q        <= level_q + LVL_W'(1);
      end else if (do_pop) begin
        level_q <= level_q - LVL_W'(1);
      end
      if (do_xchg) stk_q[top_idx] <= cur;
      if (st_err)          err_q <= 1'b1;
      else if (fb.err_clr) err_q <= 1'b0;
    end
  end
endmodule

// File: doc/sm83_alu_flags_bank.md
Name: sm83_alu_flags_bank

Overview:
Parametrised next-generation SM83 flag unit. Holds Z/N/H and primary C, a bank of NSEC selectable secondary carry registers, and a DAA half-carry register. Adds a SHADOW_DEPTH-deep flag save/restore stack for interrupt/context entry and exit. Sits between the ALU and control decoder, with flags visible on the data bus via dout[7:4].

Parameters:
NSEC, 2, number of secondary carry registers (>=1)
SHADOW_DEPTH, 2, shadow stack entries (>=1); each entry holds {Z,N,H,C}
LVL_W, $clog2(SHADOW_DEPTH+1), width of shadow_level
SEL_W, (NSEC>1 ? $clog2(NSEC) : 1), width of secondary select

Ports:
clk  in  1  clock, all state updates on posedge
nreset  in  1  reset
din  in  8  flags from data bus (Z=7, N=6, H=5, C=4)
dout  out  8  {zero,neg,half_carry,carry,4'b0}
flags_bus / flags_alu  in  1 each  write source select; one-hot whenever any *_we is high
zero_we, zero_clr  in  1  Z update / clear
neg_we, neg_set, neg_clr  in  1  N update / set / clear (clr beats set)
hc_we, hc_set, hc_cpl  in  1  H update; output force-1; output invert
daa_we  in  1  DAA half-carry update
carry_we, carry_set, carry_cpl  in  1  primary C update; output force-1; output invert
sec_we  in  1  write secondary carry sec_wsel
sec_src  in  2  00 carry_in, 01 shift_out_in, 10 daa_carry_in, 11 constant 0
sec_wsel, sec_rsel  in  SEL_W  secondary write / read index
sec_sel  in  1  carry output taken from secondary reg sec_rsel
zero_in, carry_in, shift_out_in, daa_carry_in, sign_in  in  1  ALU inputs
push, pop, err_clr  in  1  shadow stack controls
zero, neg, half_carry, daa_carry, carry, pri_carry  out  1  flag outputs
shadow_level  out  LVL_W  occupied entries
shadow_full, shadow_empty, shadow_err  out  1  stack status

Behaviour:
- Reset synchronous, active-low: while nreset=0 at posedge, all flag/secondary/DAA regs, stack entries, shadow_level, and shadow_err -> 0. Shadow_empty=1 and shadow_full=0 after reset. Reset beats every other input.
- Writes take effect on the next posedge. Outputs are purely registered plus the output combinational terms. Latency is 1 cycle.
- Z: zero_clr -> 0, else din[7] (bus) or zero_in (alu). N: neg_clr -> 0, neg_set -> 1, else din[6] or sign_in.
- H reg (hc_we) and DAA reg (daa_we): din[5] or carry_in. Primary C (carry_we && !sec_we): din[4] or carry_in.
- sec_we writes only reg sec_wsel; sec_wsel >= NSEC ignored.
- half_carry = (H | hc_set) ^ hc_cpl.
- carry = ((sec_sel ? sec[sec_rsel] : pri_carry) | carry_set) ^ carry_cpl. Out-of-range sec_rsel reads 0.
- Stack is LIFO. push (not pop): if not full, store current {Z,N,H,pri_C} (pre-update values), level+1; same-cycle flag writes still apply.
- pop (not push): if not empty, Z,N,H,pri_C load top entry, level-1; pop overrides same-cycle zero/neg/hc/carry writes. Secondary and DAA regs untouched.
- push&&pop, non-empty: exchange; flags load top, top <- current flags, level unchanged, flag writes dropped.
- push&&pop, empty: treated as push; shadow_err set.
- Push when full or pop when empty: no state change except shadow_err <- 1.
- shadow_err is sticky; cleared by err_clr (err_clr loses to a same-cycle new error).
- shadow_full = (level==SHADOW_DEPTH); shadow_empty = (level==0).

Optional Feature:
SM83_FLAGS_BYPASS_EN: when defined, zero/neg/half_carry/carry/pri_carry/dout show the value being written this cycle, including pop-restored values (write-through, combinational from inputs). The register update is unchanged. When undefined, outputs reflect register state only (1-cycle latency).

Test Plan:
- Reset: drive nreset=0 with all *_we=1 and din=8'hF0 -> next cycle dout=8'h00, shadow_empty=1, shadow_level=0, shadow_err=0.
- Flag write: flags_bus, din=8'hB0, zero_we/neg_we/hc_we/carry_we -> dout=8'hB0; then carry_cpl=1 -> carry=0; hc_set=1 -> half_carry=1.
- Secondary bank (NSEC=2): sec_we, sec_wsel=1, sec_src=01, shift_out_in=1, plus carry_we with carry_in=0 -> sec[1]=1, pri_carry unchanged; sec_sel=1, sec_rsel=1 -> carry=1; sec_rsel=0 -> carry=0.
- Stack: flags 8'hF0, push; flags written 8'h00, push -> shadow_full=1, level=2; third push -> shadow_err=1, level=2; pop -> dout=8'h00; pop -> dout=8'hF0, shadow_empty=1.
- Exchange: flags 8'h10, stack top 8'h80, push&&pop -> dout=8'h80, top becomes 8'h10, level unchanged; pop on empty -> shadow_err=1, flags unchanged; err_clr -> shadow_err=0.
- Mid-operation reset: level=1 with flags 8'hA0, nreset=0 together with pop -> flags 8'h00, level=0, no error.
